// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: geometry defaults,
// FSM state encoding and boolean constants used across the fetch stages.
package icache_pkg;

  localparam int IC_INDEX_BITS  = 6;
  localparam int IC_OFFSET_BITS = 4;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_LOOKUP  = 2'd1,
    IC_REFILL  = 2'd2,
    IC_RESPOND = 2'd3
  } ic_state_e;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data array: one word-wide write port used by the refill
// and one registered read port addressed by index and word offset.
module icache_data_ram #(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] w_idx,
  input  logic [WORD_BITS-1:0]  w_word,
  input  logic [31:0]           w_data,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] r_idx,
  input  logic [WORD_BITS-1:0]  r_word,
  output logic [31:0]           r_data
);

  localparam int DEPTH = 1 << (INDEX_BITS + WORD_BITS);

  logic [31:0] mem [DEPTH];
  logic [31:0] r_data_q;

  // Synchronous write and enabled registered read; the read register holds
  // its value between accepted fetches so a stalled lookup sees stable data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{w_idx, w_word}] <= w_data;
    end
    if (re) begin
      r_data_q <= mem[{r_idx, r_word}];
    end
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Holds tags, valid bits and
// the lookup/refill FSM; instruction words live in icache_data_ram.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = IC_INDEX_BITS,
  parameter int OFFSET_BITS = IC_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        IF_pc_sgn,
  input  logic [31:0] IF_pc,
  output logic        IF_ins_sgn,
  output logic [31:0] IF_ins,
  output logic        MC_req,
  output logic [31:0] MC_addr,
  input  logic        MC_ready,
  input  logic [31:0] MC_data
);

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int WORD_BITS = OFFSET_BITS - 2;
  localparam int TAG_BITS  = 32 - INDEX_BITS - OFFSET_BITS;
  localparam logic [WORD_BITS-1:0] LAST_WORD = '1;

  ic_state_e            state_q, state_d;
  logic [31:0]          req_pc_q, req_pc_d;
  logic [WORD_BITS-1:0] cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic                 mc_req_q, mc_req_d;
  logic [31:0]          mc_addr_q, mc_addr_d;
  logic [31:0]          fill_q, fill_d;

  logic [TAG_BITS-1:0]  tag_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [WORD_BITS-1:0]  req_word;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic                  accept;
  logic                  ins_sgn;
  logic                  ram_we;
  logic                  tag_we;
  logic [31:0]           ram_rdata;
  logic                  unused_pc_bits;

  assign req_idx        = req_pc_q[OFFSET_BITS +: INDEX_BITS];
  assign req_word       = req_pc_q[2 +: WORD_BITS];
  assign req_tag        = req_pc_q[31 -: TAG_BITS];
  assign hit            = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_pc_bits = ^req_pc_q[1:0];

  // Next-state logic; rdy low leaves every register and the arrays untouched.
  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    mc_req_d  = mc_req_q;
    mc_addr_d = mc_addr_q;
    fill_d    = fill_q;
    accept    = False;
    ins_sgn   = False;
    ram_we    = False;
    tag_we    = False;
    if (rdy) begin
      case (state_q)
        IC_IDLE: begin
          if (IF_pc_sgn && !clear) begin
            accept = True;
          end
        end
        IC_LOOKUP: begin
          if (clear) begin
            state_d = IC_IDLE;
          end else if (hit) begin
            ins_sgn = True;
            if (IF_pc_sgn) begin
              accept = True;
            end else begin
              state_d = IC_IDLE;
            end
          end else begin
            // Invalidate first so an aborted refill never leaves a stale line.
            valid_d[req_idx] = False;
            cnt_d            = '0;
            mc_req_d         = True;
            mc_addr_d        = {req_pc_q[31:OFFSET_BITS], {WORD_BITS{1'b0}}, 2'b00};
            state_d          = IC_REFILL;
          end
        end
        IC_REFILL: begin
          if (clear) begin
            drop_d = True;
          end
          if (MC_ready) begin
            ram_we   = True;
            mc_req_d = False;
            // Keep the requested word aside so RESPOND does not race the
            // array write of the final word.
            if (cnt_q == req_word) begin
              fill_d = MC_data;
            end
            if (cnt_q == LAST_WORD) begin
              valid_d[req_idx] = True;
              tag_we           = True;
              cnt_d            = '0;
              drop_d           = False;
              state_d          = (drop_q || clear) ? IC_IDLE : IC_RESPOND;
            end else begin
              cnt_d     = cnt_q + 1'b1;
              mc_addr_d = {req_pc_q[31:OFFSET_BITS], cnt_d, 2'b00};
            end
          end else if (!mc_req_q) begin
            mc_req_d = True;
          end
        end
        IC_RESPOND: begin
          if (clear) begin
            state_d = IC_IDLE;
          end else begin
            ins_sgn = True;
            if (IF_pc_sgn) begin
              accept = True;
            end else begin
              state_d = IC_IDLE;
            end
          end
        end
        default: state_d = IC_IDLE;
      endcase
      if (accept) begin
        req_pc_d = IF_pc;
        state_d  = IC_LOOKUP;
      end
    end
  end

  // FSM, control and address registers; reset drops any refill in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IC_IDLE;
      req_pc_q  <= '0;
      cnt_q     <= '0;
      drop_q    <= False;
      valid_q   <= '0;
      mc_req_q  <= False;
      mc_addr_q <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      valid_q   <= valid_d;
      mc_req_q  <= mc_req_d;
      mc_addr_q <= mc_addr_d;
      fill_q    <= fill_d;
    end
  end

  // Tag array is written once per completed refill; contents need no reset.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

  icache_data_ram #(
    .INDEX_BITS(INDEX_BITS),
    .WORD_BITS (WORD_BITS)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .w_idx (req_idx),
    .w_word(cnt_q),
    .w_data(MC_data),
    .re    (accept),
    .r_idx (IF_pc[OFFSET_BITS +: INDEX_BITS]),
    .r_word(IF_pc[2 +: WORD_BITS]),
    .r_data(ram_rdata)
  );

  assign IF_ins_sgn = ins_sgn;
  assign IF_ins     = ins_sgn ? ((state_q == IC_RESPOND) ? fill_q : ram_rdata) : 32'h0;
  assign MC_req     = mc_req_q;
  assign MC_addr    = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: a random-latency memory responder, a tag/valid model of
// the cache contents, and per-scenario tasks checking responses and refills.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        IF_pc_sgn = 1'b0;
  logic [31:0] IF_pc = 32'h0;
  logic        IF_ins_sgn;
  logic [31:0] IF_ins;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_ready = 1'b0;
  logic [31:0] MC_data = 32'h0;

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clear     (clear),
    .IF_pc_sgn (IF_pc_sgn),
    .IF_pc     (IF_pc),
    .IF_ins_sgn(IF_ins_sgn),
    .IF_ins    (IF_ins),
    .MC_req    (MC_req),
    .MC_addr   (MC_addr),
    .MC_ready  (MC_ready),
    .MC_data   (MC_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        obs_sgn, obs_req, obs_ready;
  logic [31:0] obs_ins, obs_addr;

  bit          m_valid [64];
  bit   [21:0] m_tag   [64];
  logic [31:0] salt;

  int          mc_wait = 0;
  int          clr_with_ready = 0;
  bit          auto_clr = 0;

  bit          mon_on = 0;
  logic [31:0] mon_base;
  int          nready, since_ready, pulses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Memory controller: answers a pending request after 0..2 idle cycles.
  task automatic mc_drive();
    MC_ready = 1'b0;
    if (rst && rdy && MC_req) begin
      if (mc_wait == 0) begin
        MC_ready = 1'b1;
        MC_data  = mem_word(MC_addr);
        mc_wait  = int'($urandom_range(2));
        if (clr_with_ready != 0 && nready + 1 == clr_with_ready) begin
          clear    = 1'b1;
          auto_clr = 1'b1;
        end
      end else begin
        mc_wait--;
      end
    end
  endtask

  // One clock cycle: respond, sample outputs, watch the refill protocol.
  task automatic cycle();
    mc_drive();
    #1;
    obs_sgn   = IF_ins_sgn;
    obs_ins   = IF_ins;
    obs_req   = MC_req;
    obs_addr  = MC_addr;
    obs_ready = MC_ready;
    if (mon_on && rdy && rst) begin
      if (obs_req) begin
        vectors++;
        if (obs_addr !== mon_base + 32'(4 * nready)) begin
          miscompares++;
          $display("FAIL mc_addr: got %08h want %08h", obs_addr, mon_base + 32'(4 * nready));
        end
      end
      if (since_ready == 1) begin
        vectors++;
        if (obs_req !== 1'b0) begin
          miscompares++;
          $display("FAIL mc_req_gap: got %b want 0", obs_req);
        end
      end
      if (since_ready == 2 && nready < 4) begin
        vectors++;
        if (obs_req !== 1'b1) begin
          miscompares++;
          $display("FAIL mc_req_resume: got %b want 1", obs_req);
        end
      end
      if (obs_sgn) pulses++;
      if (obs_ready) begin
        nready++;
        since_ready = 1;
      end else if (since_ready > 0) begin
        since_ready++;
      end
    end
    @(posedge clk);
    #1;
    if (auto_clr) begin
      clear    = 1'b0;
      auto_clr = 1'b0;
    end
  endtask

  task automatic mon_start(input logic [31:0] base);
    mon_on      = 1'b1;
    mon_base    = base;
    nready      = 0;
    since_ready = 0;
    pulses      = 0;
  endtask

  task automatic wait_readies(input int n);
    int guard = 0;
    while (nready < n && guard < 100) begin
      cycle();
      guard++;
    end
    vectors++;
    if (nready < n) begin
      miscompares++;
      $display("FAIL refill_timeout: got %0d readies want %0d", nready, n);
    end
  endtask

  // One fetch; hit or miss is predicted from the tag/valid model.
  task automatic fetch(input logic [31:0] pc, input int clr_after, input int clr_with);
    logic [5:0]  idx;
    logic [21:0] tag;
    bit          exp_hit, drop;
    logic [31:0] exp_ins;
    idx     = pc[9:4];
    tag     = pc[31:10];
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    exp_ins = mem_word({pc[31:2], 2'b00});
    drop    = (clr_after > 0) || (clr_with > 0);
    IF_pc = pc;
    IF_pc_sgn = 1'b1;
    cycle();
    IF_pc_sgn = 1'b0;
    vectors++;
    if (obs_sgn !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_pulse pc=%08h: got %b want 0", pc, obs_sgn);
    end
    if (exp_hit) begin
      cycle();
      vectors++;
      if (obs_sgn !== 1'b1 || obs_ins !== exp_ins) begin
        miscompares++;
        $display("FAIL hit pc=%08h: got sgn=%b ins=%08h want sgn=1 ins=%08h", pc, obs_sgn, obs_ins, exp_ins);
      end
      vectors++;
      if (obs_req !== 1'b0) begin
        miscompares++;
        $display("FAIL hit_mc_req pc=%08h: got %b want 0", pc, obs_req);
      end
    end else begin
      mon_start({pc[31:4], 4'h0});
      clr_with_ready = clr_with;
      cycle();
      vectors++;
      if (obs_sgn !== 1'b0) begin
        miscompares++;
        $display("FAIL lookup_miss pc=%08h: got sgn=%b want 0", pc, obs_sgn);
      end
      if (clr_after > 0) begin
        wait_readies(clr_after);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
      end
      wait_readies(4);
      clr_with_ready = 0;
      vectors++;
      if (pulses != 0) begin
        miscompares++;
        $display("FAIL refill_pulse pc=%08h: got %0d pulses want 0", pc, pulses);
      end
      cycle();
      vectors++;
      if (drop) begin
        if (obs_sgn !== 1'b0) begin
          miscompares++;
          $display("FAIL dropped_pulse pc=%08h: got sgn=%b want 0", pc, obs_sgn);
        end
      end else if (obs_sgn !== 1'b1 || obs_ins !== exp_ins) begin
        miscompares++;
        $display("FAIL miss_resp pc=%08h: got sgn=%b ins=%08h want sgn=1 ins=%08h", pc, obs_sgn, obs_ins, exp_ins);
      end
      cycle();
      vectors++;
      if (obs_sgn !== 1'b0 || obs_req !== 1'b0) begin
        miscompares++;
        $display("FAIL post_idle pc=%08h: got sgn=%b req=%b want 0 0", pc, obs_sgn, obs_req);
      end
      mon_on = 1'b0;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    $display("fetch pc=%08h %s%s ins=%08h", pc, exp_hit ? "hit" : "miss", (drop && !exp_hit) ? " dropped" : "", exp_ins);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (IF_ins_sgn !== 1'b0) begin miscompares++; $display("FAIL reset_sgn: got %b want 0", IF_ins_sgn); end
    vectors++;
    if (IF_ins !== 32'h0) begin miscompares++; $display("FAIL reset_ins: got %08h want 0", IF_ins); end
    vectors++;
    if (MC_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", MC_req); end
    vectors++;
    if (MC_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %08h want 0", MC_addr); end
    rst = 1'b1;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    cycle();
    vectors++;
    if (obs_sgn !== 1'b0 || obs_req !== 1'b0 || obs_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got sgn=%b req=%b addr=%08h want 0 0 0", obs_sgn, obs_req, obs_addr);
    end
    $display("reset released");
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h4;
    pcs[1] = 32'h8;
    pcs[2] = 32'hC;
    for (int k = 0; k <= 3; k++) begin
      IF_pc_sgn = (k < 3);
      if (k < 3) IF_pc = pcs[k];
      cycle();
      vectors++;
      if (k == 0) begin
        if (obs_sgn !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_first: got sgn=%b want 0", obs_sgn);
        end
      end else begin
        if (obs_sgn !== 1'b1 || obs_ins !== mem_word(pcs[k-1]) || obs_req !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_hit pc=%08h: got sgn=%b ins=%08h req=%b want 1 %08h 0", pcs[k-1], obs_sgn, obs_ins, obs_req, mem_word(pcs[k-1]));
        end
        $display("b2b hit pc=%08h ins=%08h", pcs[k-1], obs_ins);
      end
    end
    IF_pc_sgn = 1'b0;
    cycle();
  endtask

  task automatic test_flush_hit();
    IF_pc = 32'h8;
    IF_pc_sgn = 1'b1;
    cycle();
    clear = 1'b1;
    IF_pc = 32'h4;
    cycle();
    vectors++;
    if (obs_sgn !== 1'b0) begin miscompares++; $display("FAIL flush_hit_pulse: got %b want 0", obs_sgn); end
    clear = 1'b0;
    IF_pc_sgn = 1'b0;
    cycle();
    vectors++;
    if (obs_sgn !== 1'b0) begin miscompares++; $display("FAIL flush_hit_accept: got %b want 0", obs_sgn); end
    clear = 1'b1;
    IF_pc_sgn = 1'b1;
    cycle();
    clear = 1'b0;
    IF_pc_sgn = 1'b0;
    cycle();
    vectors++;
    if (obs_sgn !== 1'b0) begin miscompares++; $display("FAIL idle_clear_accept: got %b want 0", obs_sgn); end
    $display("flush on hit pc=00000008 cancelled");
    fetch(32'h4, 0, 0);
  endtask

  task automatic test_rdy_freeze();
    IF_pc = 32'h300;
    IF_pc_sgn = 1'b1;
    cycle();
    IF_pc_sgn = 1'b0;
    mon_start(32'h300);
    cycle();
    wait_readies(1);
    cycle();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      vectors++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h304) begin
        miscompares++;
        $display("FAIL rdy_hold: got req=%b addr=%08h want 1 00000304", obs_req, obs_addr);
      end
    end
    rdy = 1'b1;
    wait_readies(4);
    cycle();
    vectors++;
    if (obs_sgn !== 1'b1 || obs_ins !== mem_word(32'h300)) begin
      miscompares++;
      $display("FAIL rdy_resp: got sgn=%b ins=%08h want 1 %08h", obs_sgn, obs_ins, mem_word(32'h300));
    end
    mon_on = 1'b0;
    m_valid[6'h30] = 1'b1;
    m_tag[6'h30]   = 22'h0;
    cycle();
    $display("rdy freeze pc=00000300 ins=%08h", obs_ins);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] pc;
      int r, ca, cw;
      pc = 32'(($urandom_range(2) << 10) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2) | $urandom_range(3));
      r  = int'($urandom_range(9));
      ca = (r == 0) ? int'($urandom_range(3, 1)) : 0;
      cw = (r == 1) ? int'($urandom_range(4, 1)) : 0;
      fetch(pc, ca, cw);
    end
  endtask

  task automatic test_reset_mid_refill();
    IF_pc = 32'h500;
    IF_pc_sgn = 1'b1;
    cycle();
    IF_pc_sgn = 1'b0;
    mon_start(32'h500);
    cycle();
    wait_readies(2);
    rst = 1'b0;
    #2;
    vectors++;
    if (IF_ins_sgn !== 1'b0 || IF_ins !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_ins: got sgn=%b ins=%08h want 0 0", IF_ins_sgn, IF_ins);
    end
    vectors++;
    if (MC_req !== 1'b0 || MC_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_mc: got req=%b addr=%08h want 0 0", MC_req, MC_addr);
    end
    mon_on  = 1'b0;
    mc_wait = 0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    $display("reset mid-refill pc=00000500");
    fetch(32'h500, 0, 0);
    fetch(32'h0, 0, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    salt = $urandom;
    test_reset();
    fetch(32'h0, 0, 0);          // cold miss
    test_back_to_back();         // sequential hits in line 0
    fetch(32'h400, 0, 0);        // conflict eviction
    fetch(32'h0, 0, 0);          // misses again
    fetch(32'h100, 2, 0);        // clear after 2nd ready, no pulse
    fetch(32'h104, 0, 0);        // line stayed consistent
    test_flush_hit();
    fetch(32'h200, 0, 4);        // clear together with last ready
    fetch(32'h20C, 0, 0);        // line valid anyway
    test_rdy_freeze();
    test_random();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
